// File: rtl/joy_db15_scan_pkg.sv
// Shared types and constants for the DB15 joystick chain scanner.
// Bit map per player word: LS F E D C B A U D L R, bit0 = R.
package joy_db15_scan_pkg;

    typedef enum logic [1:0] {LOAD, SHIFT, LATCH, IDLE} scan_state_t;

    localparam int unsigned FRAME_BITS      = 32;
    localparam int unsigned BITS_PER_PLAYER = 16;

    localparam int unsigned BTN_R     = 0;
    localparam int unsigned BTN_L     = 1;
    localparam int unsigned BTN_DOWN  = 2;
    localparam int unsigned BTN_UP    = 3;
    localparam int unsigned BTN_A     = 4;
    localparam int unsigned BTN_B     = 5;
    localparam int unsigned BTN_C     = 6;
    localparam int unsigned BTN_D     = 7;
    localparam int unsigned BTN_E     = 8;
    localparam int unsigned BTN_F     = 9;
    localparam int unsigned BTN_S     = 10;
    localparam int unsigned BTN_LTRIG = 11;

    // The chain reports pressed buttons as 0.
    function automatic logic [BITS_PER_PLAYER-1:0] to_pressed(
        input logic [BITS_PER_PLAYER-1:0] raw
    );
        return ~raw;
    endfunction

endpackage

// File: rtl/joy_db15_tick.sv
// Half-period timer for the serial chain: tick on the last cycle of each
// CLK_DIV-cycle half period, phase toggles at every tick (0 = low half).
module joy_db15_tick #(
    parameter int unsigned CLK_DIV = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tick,
    output logic phase
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/joy_db15_scan.sv
// Scanner for the DB15 UserIO adapter (four chained 74HC165s, 32 active-low bits).
// Optional macro JOY_DB15_SCAN_DEBOUNCE_EN: publish a frame only when it repeats.
module joy_db15_scan
    import joy_db15_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 8,
    parameter int unsigned SCAN_GAP = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        JOY_CLK,
    output logic        JOY_LOAD,
    input  logic        JOY_DATA,
    output logic [15:0] joystick1,
    output logic [15:0] joystick2,
    output logic        joy_valid,
    output logic        frame_strobe
);

    localparam int unsigned IDX_W = $clog2(FRAME_BITS);
    localparam int unsigned GAP_W = $clog2(SCAN_GAP + 1);

    scan_state_t            state, state_nxt;
    logic [1:0]             jd_sync;
    logic                   jd_s;
    logic [IDX_W-1:0]       bit_idx;
    logic [GAP_W-1:0]       gap_cnt;
    logic [FRAME_BITS-1:0]  shreg;
    logic                   tick, phase, tick_en;
    logic                   load_dec, clk_dec, strobe_dec;

`ifdef JOY_DB15_SCAN_DEBOUNCE_EN
    logic [FRAME_BITS-1:0]  prev_raw;
    logic                   have_prev;
`endif

    assign jd_s    = jd_sync[1];
    assign tick_en = (state == LOAD) || (state == SHIFT);

    joy_db15_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (tick_en),
        .tick    (tick),
        .phase   (phase)
    );

    // Pin levels are decoded from the current state and registered, so every
    // pin lags the internal state by exactly one cycle.
    always_comb begin
        state_nxt  = state;
        load_dec   = 1'b1;
        clk_dec    = 1'b0;
        strobe_dec = 1'b0;
        case (state)
            LOAD: begin
                load_dec = 1'b0;
                if (tick && phase) state_nxt = SHIFT;
            end
            SHIFT: begin
                clk_dec = phase;
                if (tick && phase && (bit_idx == IDX_W'(FRAME_BITS - 1))) state_nxt = LATCH;
            end
            LATCH: begin
                strobe_dec = 1'b1;
                state_nxt  = IDLE;
            end
            IDLE: begin
                if (gap_cnt == GAP_W'(SCAN_GAP - 1)) state_nxt = LOAD;
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= LOAD;
            jd_sync      <= '1;
            bit_idx      <= '0;
            gap_cnt      <= '0;
            shreg        <= '1;
            JOY_LOAD     <= 1'b1;
            JOY_CLK      <= 1'b0;
            frame_strobe <= 1'b0;
        end else begin
            state        <= state_nxt;
            jd_sync      <= {jd_sync[0], JOY_DATA};
            JOY_LOAD     <= load_dec;
            JOY_CLK      <= clk_dec;
            frame_strobe <= strobe_dec;
            gap_cnt      <= (state == IDLE) ? gap_cnt + GAP_W'(1) : '0;
            if (state == SHIFT && tick) begin
                // Sample on the edge that raises JOY_CLK: data has settled all low phase.
                if (!phase) shreg[bit_idx] <= jd_s;
                else        bit_idx        <= bit_idx + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            joystick1 <= '0;
            joystick2 <= '0;
            joy_valid <= 1'b0;
`ifdef JOY_DB15_SCAN_DEBOUNCE_EN
            prev_raw  <= '1;
            have_prev <= 1'b0;
`endif
        end else if (state == LATCH) begin
`ifdef JOY_DB15_SCAN_DEBOUNCE_EN
            if (have_prev && (shreg == prev_raw)) begin
                joystick1 <= to_pressed(shreg[BITS_PER_PLAYER-1:0]);
                joystick2 <= to_pressed(shreg[FRAME_BITS-1:BITS_PER_PLAYER]);
                joy_valid <= 1'b1;
            end
            prev_raw  <= shreg;
            have_prev <= 1'b1;
`else
            joystick1 <= to_pressed(shreg[BITS_PER_PLAYER-1:0]);
            joystick2 <= to_pressed(shreg[FRAME_BITS-1:BITS_PER_PLAYER]);
            joy_valid <= 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_joy_db15_scan.sv
// Bench for joy_db15_scan: 74HC165 chain model, expected words queued per frame,
// monitor checks each frame_strobe plus pin timing. Honours JOY_DB15_SCAN_DEBOUNCE_EN.
module tb_joy_db15_scan;

    localparam int NFRAMES = 14;
    localparam int PERIOD  = 4625;
    localparam int FIRST   = 529;
    localparam int LIMIT   = 6000;

    logic        clk      = 1'b0;
    logic        reset_n  = 1'b0;
    logic        JOY_DATA = 1'b1;
    logic        JOY_CLK, JOY_LOAD, joy_valid, frame_strobe;
    logic [15:0] joystick1, joystick2;

    always #10 clk = ~clk;

    joy_db15_scan #(.CLK_DIV(8), .SCAN_GAP(4096)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .JOY_CLK      (JOY_CLK),
        .JOY_LOAD     (JOY_LOAD),
        .JOY_DATA     (JOY_DATA),
        .joystick1    (joystick1),
        .joystick2    (joystick2),
        .joy_valid    (joy_valid),
        .frame_strobe (frame_strobe)
    );

    typedef struct packed {
        logic [15:0] j1;
        logic [15:0] j2;
        logic        v;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Raw chain contents (bit k = k-th serial bit, 0 = pressed) and expected words.
    logic [31:0] v_raw [NFRAMES] = '{32'hFFFF_FFFF, 32'hFFF7_FFFE, 32'hFFF7_FFFE, 32'hFFFF_FFEF,
                                     32'hFFFF_FFEF, 32'hFFFF_FFEF, 32'hFFFF_FFEF, 32'hFFFF_FFEF,
                                     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEF, 32'hFFFF_FFFF,
                                     32'h5A5A_C3C3, 32'h5A5A_C3C3};
    logic [15:0] v_j1 [NFRAMES] = '{16'h0000, 16'h0001, 16'h0001, 16'h0010, 16'h0010, 16'h0010,
                                     16'h0010, 16'h0010, 16'h0000, 16'h0000, 16'h0010, 16'h0000,
                                     16'h3C3C, 16'h3C3C};
    logic [15:0] v_j2 [NFRAMES] = '{16'h0000, 16'h0008, 16'h0008, 16'h0000, 16'h0000, 16'h0000,
                                     16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000,
                                     16'hA5A5, 16'hA5A5};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic finish_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    task automatic bail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out after %0d cycles", name, LIMIT);
        finish_run();
    endtask

    // 74HC165 chain: parallel load while JOY_LOAD low, shift on JOY_CLK rise,
    // QH settling one clk cycle after the rise; serial input pulled high.
    logic [31:0] chain_vec = '1;
    logic [31:0] sr        = '1;

    always @(negedge JOY_LOAD or posedge JOY_CLK) begin
        if (!JOY_LOAD) begin
            sr       = chain_vec;
            JOY_DATA = sr[0];
        end else begin
            sr = {1'b1, sr[31:1]};
            @(posedge clk);
            #1;
            JOY_DATA = sr[0];
        end
    end

    // Reference model of the published words.
    logic [15:0] m_j1   = '0;
    logic [15:0] m_j2   = '0;
    logic        m_v    = 1'b0;
    logic [31:0] m_prev = '1;
    bit          m_have = 1'b0;

    task automatic push_exp(input int i);
`ifdef JOY_DB15_SCAN_DEBOUNCE_EN
        if (m_have && v_raw[i] == m_prev) begin
            m_j1 = v_j1[i];
            m_j2 = v_j2[i];
            m_v  = 1'b1;
        end
        m_prev = v_raw[i];
        m_have = 1'b1;
`else
        m_j1 = v_j1[i];
        m_j2 = v_j2[i];
        m_v  = 1'b1;
`endif
        exp_q.push_back('{m_j1, m_j2, m_v});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_joy_clk"},  JOY_CLK, 0);
        check({tag, "_joy_load"}, JOY_LOAD, 1);
        check({tag, "_j1"},       joystick1, 0);
        check({tag, "_j2"},       joystick2, 0);
        check({tag, "_valid"},    joy_valid, 0);
        check({tag, "_strobe"},   frame_strobe, 0);
    endtask

    task automatic wait_strobe(input int start, output int n);
        n = start;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_strobe && n < LIMIT);
        if (!frame_strobe) bail("wait_frame_strobe");
    endtask

    // Monitor: pops one expectation per strobe and checks pin timing between strobes.
    int   cyc = 0, last = 0, rises = 0, changes = 0, bad_hi = 0, hi_len = 0, low_len = 0, both = 0;
    bit   have_last = 1'b0;
    logic p_clk = 1'b0, p_load = 1'b1;
    logic [32:0] prev_out = '0;
    exp_t e;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            have_last = 1'b0;
            rises = 0; changes = 0; bad_hi = 0; hi_len = 0; low_len = 0; both = 0;
        end else begin
            if (JOY_CLK && !p_clk) rises++;
            if (JOY_CLK) hi_len++;
            else if (p_clk) begin
                if (hi_len != 8) bad_hi++;
                hi_len = 0;
            end
            if (!JOY_LOAD) low_len++;
            else if (!p_load) begin
                check("load_low_cycles", low_len, 16);
                low_len = 0;
            end
            if (!JOY_LOAD && JOY_CLK) both++;
            if (frame_strobe) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: got strobe at cycle %0d, expected none", cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("joystick1", joystick1, e.j1);
                    check("joystick2", joystick2, e.j2);
                    check("joy_valid", joy_valid, e.v);
                end
                if (have_last) check("strobe_period", cyc - last, PERIOD);
                check("clk_rises_per_frame", rises, 32);
                check("clk_high_len_errors", bad_hi, 0);
                check("changes_between_strobes", changes, 0);
                check("load_clk_overlap", both, 0);
                rises = 0; changes = 0; bad_hi = 0; both = 0;
                last = cyc;
                have_last = 1'b1;
            end else if ({joystick1, joystick2, joy_valid} != prev_out) begin
                changes++;
            end
        end
        p_clk    = JOY_CLK;
        p_load   = JOY_LOAD;
        prev_out = {joystick1, joystick2, joy_valid};
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        check_reset("reset");
        chain_vec = v_raw[0];
        push_exp(0);
        reset_n = 1'b1;
        @(negedge clk);
        check("load_after_release", JOY_LOAD, 0);
        wait_strobe(1, n);
        check("first_frame_cycles", n, FIRST);

        for (int i = 1; i < 5; i++) begin
            chain_vec = v_raw[i];
            push_exp(i);
            wait_strobe(0, n);
        end

        // Abort frame 5 in the low phase of bit slot 20.
        chain_vec = v_raw[5];
        n = 0;
        while (JOY_LOAD && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (JOY_LOAD) bail("wait_load");
        repeat (340) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_reset("mid_frame_reset");
        m_j1 = '0; m_j2 = '0; m_v = 1'b0; m_have = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        chain_vec = v_raw[6];
        push_exp(6);
        reset_n = 1'b1;
        @(negedge clk);
        check("load_after_rerelease", JOY_LOAD, 0);
        wait_strobe(1, n);
        check("frame_after_reset_cycles", n, FIRST);

        for (int i = 7; i < NFRAMES; i++) begin
            chain_vec = v_raw[i];
            push_exp(i);
            wait_strobe(0, n);
        end

        repeat (5) @(negedge clk);
        check("pending_expectations", exp_q.size(), 0);
        finish_run();
    end

endmodule

// File: doc/joy_db15_scan.md
Name: joy_db15_scan

Overview:
- Serial scanner for the DB15 UserIO joystick adapter, a chain of four 74HC165 shift registers holding 32 active-low button bits.
- Sits directly upstream of the core's joystick mux.
- Drives the adapter's load/clock pins, deserialises the returned bits and presents two 16-bit active-high joystick words, updated atomically once per scan frame.

Parameters:
- CLK_DIV, 8: clk cycles per serial half-period. Minimum 4, for synchroniser margin.
- SCAN_GAP, 4096: idle clk cycles between the end of one frame and the next load.

Ports:
- clk  in  1  system clock, 40-50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- JOY_CLK  out  1  serial clock to the 74HC165 chain; idle low; the chain shifts on its rising edge.
- JOY_LOAD  out  1  parallel load, active low; idle high.
- JOY_DATA  in  1  serial data from the chain (QH), asynchronous, active low.
- joystick1  out  16  player 1 buttons, active high; bit map LS FEDCBAUDLR, bit0 = R.
- joystick2  out  16  player 2 buttons, same map.
- joy_valid  out  1  high once the first complete frame has been latched.
- frame_strobe  out  1  one-cycle pulse in the LATCH state of every frame.

Behaviour:
- Reset values: JOY_CLK=0, JOY_LOAD=1, joystick1=0, joystick2=0, joy_valid=0, frame_strobe=0. State is LOAD, counters are 0, and the shift register is all ones.
- JOY_DATA passes through a 2-flop synchroniser (jd_s) before any use.
- State machine:
  - LOAD: JOY_LOAD=0 for 2*CLK_DIV cycles, JOY_CLK=0 -> SHIFT.
  - SHIFT: 32 bit slots k=0..31, each 2*CLK_DIV cycles.
    - Low phase (JOY_CLK=0) for CLK_DIV cycles. Sample jd_s on the last low-phase cycle into shift-register position k.
    - High phase (JOY_CLK=1) for CLK_DIV cycles.
    - After k=31 high phase -> LATCH.
  - LATCH: 1 cycle.
    - joystick1[i] <= ~bit[i] for i=0..15; joystick2[i] <= ~bit[16+i].
    - frame_strobe=1; joy_valid<=1 (sticky until reset).
    - -> IDLE.
  - IDLE: JOY_LOAD=1, JOY_CLK=0 for SCAN_GAP cycles -> LOAD.
- Frame period is SCAN_GAP + 66*CLK_DIV + 1 cycles; 4625 with defaults. The first LOAD begins on the first clk edge after reset_n deasserts.
- Outputs change only in LATCH. A partial frame is never visible.
- Reset asserted mid-frame: all outputs take their reset values immediately (async) and the partial frame is discarded. Scanning restarts at LOAD after release.
- Disconnected adapter: JOY_DATA is pulled high, so all bits read 1 and both joysticks read 0.
- JOY_LOAD and JOY_CLK are registered outputs, glitch-free, and never both active.

Optional Feature:
- Macro: JOY_DB15_SCAN_DEBOUNCE_EN.
- With the macro defined:
  - The previous raw 32-bit frame is held.
  - In LATCH, the outputs update only if the new raw frame equals the previous raw frame; the previous raw frame is then replaced by the new one.
  - frame_strobe still pulses every frame.
  - joy_valid sets at the first LATCH whose frame matches its predecessor.
  - This adds one frame of latency and rejects single-frame glitches.
- Without the macro: outputs update at every LATCH, as described in Behaviour.

Decomposition:
- Package joy_db15_scan_pkg holds:
  - state enum {LOAD, SHIFT, LATCH, IDLE};
  - FRAME_BITS=32, BITS_PER_PLAYER=16;
  - bit-index localparams (R=0, L=1, D=2, U=3, A=4 ... S=10, L-trigger=11).
- Sub-module joy_db15_tick: a CLK_DIV counter producing a half-period tick and phase flag, used by the LOAD and SHIFT timing.

Test Plan:
- Reset and release with an all-ones chain model: JOY_LOAD low for exactly 16 cycles starting 1 cycle after release. After the first frame (529 cycles), joystick1=joystick2=0, joy_valid=1, one frame_strobe.
- Chain holds player 1 R pressed (serial bit0=0) and player 2 U pressed (serial bit19=0): after LATCH, joystick1=16'h0001 and joystick2=16'h0008, with no intermediate values between strobes.
- Free run with defaults: successive frame_strobe pulses exactly 4625 cycles apart. Exactly 32 JOY_CLK rising edges per frame, each high for 8 cycles.
- reset_n pulsed low during SHIFT bit 20 with joystick1=16'h0010 latched: joystick1 reads 0 at once and joy_valid=0. The next LOAD follows release and the new frame reloads correctly.
- CLK_DIV=4 with JOY_DATA changing 1 cycle after each JOY_CLK rise: all 32 bits captured correctly; frame period 4096+265=4361.
- With JOY_DB15_SCAN_DEBOUNCE_EN: a single frame with bit4=0 amid all-ones frames leaves joystick1=0. Two consecutive such frames give joystick1=16'h0010 at the second LATCH.
